// File: rtl/fpu_div_issue_pkg.sv
// fpu_div_issue_pkg: shared FP types, core status types and issue-state constants
package fpu_div_issue_pkg;
  typedef logic [15:0] fp16_t;
  typedef logic [31:0] fp32_t;
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
    logic unordered;
  } condCode_t;
  typedef struct packed {
    logic invalid;
    logic divByZero;
    logic overflow;
    logic underflow;
    logic inexact;
  } opStatusFlag_t;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
endpackage

// File: rtl/fpu_req_fifo.sv
// fpu_req_fifo: request buffer in front of the divider, registered ready
//   clock/reset  posedge clock, async active-high reset
//   push/din     write an entry (caller gates with ready)
//   pop          retire the head entry
//   dout         head entry, zero while empty
//   ready        count != DEPTH, registered
//   count        occupancy
module fpu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 36,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          ready,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign dout = count != '0 ? mem[rd_ptr] : '0;
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count_nxt;
      ready  <= count_nxt != CW'(DEPTH);
    end
endmodule

// File: rtl/fpu_div_issue.sv
// fpu_div_issue: queues divide requests and runs them one at a time through fpuDiv
//   clock/reset                 posedge clock, async active-high reset
//   req*                        valid/ready request: operands + tag
//   rsp*                        valid/ready response: quotient, tag, core status
//   divIn1/divIn2/divStart      to the core
//   divOut/divDone/divCond*/divFlags  from the core
//   busy                        queue non-empty or an op in progress
module fpu_div_issue
  import fpu_div_issue_pkg::*;
#(
  parameter type FP_T = fp16_t,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          reqValid,
  output logic          reqReady,
  input  FP_T           reqIn1,
  input  FP_T           reqIn2,
  input  logic [TAG_W-1:0] reqTag,
  output logic          rspValid,
  input  logic          rspReady,
  output FP_T           rspOut,
  output logic [TAG_W-1:0] rspTag,
  output condCode_t     rspCondCodes,
  output opStatusFlag_t rspFlags,
  output FP_T           divIn1,
  output FP_T           divIn2,
  output logic          divStart,
  input  FP_T           divOut,
  input  logic          divDone,
  input  condCode_t     divCondCodes,
  input  opStatusFlag_t divFlags,
  output logic          busy
);
  localparam int FW = $bits(FP_T);
  localparam int EW = TAG_W + 2 * FW;
  localparam int CW = $clog2(DEPTH + 1);
  logic [1:0]    state, state_nxt;
  logic [EW-1:0] head;
  logic [CW-1:0] count;
  logic          push, pop;
  assign push = reqValid & reqReady;
  // The head is retired the moment its result is captured, so the queue frees
  // a slot while the response may still be waiting on the consumer.
  assign pop = state == WAIT && divDone;
  fpu_req_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({reqTag, reqIn2, reqIn1}),
    .dout(head),
    .ready(reqReady),
    .count(count)
  );
  assign divIn1   = FP_T'(head[FW-1:0]);
  assign divIn2   = FP_T'(head[2*FW-1:FW]);
  assign divStart = state == START;
  assign busy     = count != '0 || state != IDLE;
  always_comb
    state_nxt = state == IDLE  ? (count != '0 && !rspValid ? START : IDLE) :
                state == START ? WAIT :
                state == WAIT  ? (divDone ? RESP : WAIT) :
                                 (rspReady ? IDLE : RESP);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state        <= IDLE;
      rspValid     <= 1'b0;
      rspOut       <= '0;
      rspTag       <= '0;
      rspCondCodes <= '0;
      rspFlags     <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        rspValid     <= 1'b1;
        rspOut       <= divOut;
        rspTag       <= head[EW-1-:TAG_W];
        rspCondCodes <= divCondCodes;
        rspFlags     <= divFlags;
      end else if (state == RESP && rspReady) rspValid <= 1'b0;
    end
endmodule
